// File: rtl/multi_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_if
//   Bundle between the multi-cycle control FSM and the CPU datapath.
//   master : the controller (consumes IR fields / ALU zero / memory ready,
//            drives every datapath enable and select)
//   slave  : the datapath side (mirror image of master)
// Signals
//   opcode, funct  IR[31:26] / IR[5:0]
//   zero           ALU zero flag
//   mem_ready      memory handshake completion
//   pc_we, pc_src, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst,
//   mem_to_reg, alu_src_a, alu_src_b, alu_op   datapath controls
//   state, illegal, retire                     status / debug
// ---------------------------------------------------------------------------
interface multi_cycle_ctrl_if #(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 4
);
  logic [OP_W-1:0]     opcode;
  logic [OP_W-1:0]     funct;
  logic                zero;
  logic                mem_ready;
  logic                pc_we;
  logic [1:0]          pc_src;
  logic                ir_we;
  logic                mem_rd;
  logic                mem_wr;
  logic                iord;
  logic                reg_we;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [2:0]          state;
  logic                illegal;
  logic                retire;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pc_src, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal, retire
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pc_src, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal, retire
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Control FSM of the multi-period CPU. Walks each instruction through
//   IF/ID/EX/MEM/WB and decodes the datapath enables/selects from the
//   current state plus opcode/funct. IF and MEM stall on mem_ready.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset; all outputs read 0 while low
//   bus        multi_cycle_ctrl_if.master (IR fields, zero, mem_ready in;
//              datapath controls, state, illegal, retire out)
//   cyc_cnt    clock cycles with rst high  (CTRL_PERF_CNT_EN only)
//   ret_cnt    retired instructions        (CTRL_PERF_CNT_EN only)
// Build option
//   CTRL_PERF_CNT_EN : adds the two wrapping performance counters.
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 4
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  multi_cycle_ctrl_if.master bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OPC_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OPC_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OPC_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OPC_J    = OP_W'(6'b000010);

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

  state_e              state_q, state_d;
  logic                illegal_q, illegal_d;

  logic                pc_we, ir_we, mem_rd, mem_wr, iord;
  logic                reg_we, reg_dst, mem_to_reg, alu_src_a, retire;
  logic [1:0]          pc_src, alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                is_legal;

  assign is_legal = (bus.opcode == OPC_R)    || (bus.opcode == OPC_LW)  ||
                    (bus.opcode == OPC_SW)   || (bus.opcode == OPC_ADDI) ||
                    (bus.opcode == OPC_BEQ)  || (bus.opcode == OPC_J);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = S_IF;
    illegal_d  = illegal_q;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    ir_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_ADD;
    retire     = 1'b0;

    case (state_q)
      S_IF: begin
        // PC+4 computed by the ALU while the fetch is outstanding
        mem_rd    = 1'b1;
        alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        // Speculative branch target: PC + (imm << 2)
        alu_src_b = 2'd3;
        if (is_legal) state_d = S_EX;
        else          illegal_d = 1'b1;
      end
      S_EX: begin
        case (bus.opcode)
          OPC_R: begin
            alu_src_a = 1'b1;
            case (bus.funct)
              FN_SUB:  alu_op = ALU_SUB;
              FN_AND:  alu_op = ALU_AND;
              FN_OR:   alu_op = ALU_OR;
              FN_SLT:  alu_op = ALU_SLT;
              FN_ADD:  alu_op = ALU_ADD;
              default: alu_op = ALU_ADD;
            endcase
            state_d = S_WB;
          end
          OPC_LW, OPC_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_MEM;
          end
          OPC_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_WB;
          end
          OPC_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'd1;
            pc_we     = bus.zero;
            retire    = 1'b1;
          end
          OPC_J: begin
            pc_src = 2'd2;
            pc_we  = 1'b1;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Request held stable until the ready cycle
        iord   = 1'b1;
        mem_rd = (bus.opcode == OPC_LW);
        mem_wr = (bus.opcode == OPC_SW);
        retire = (bus.opcode == OPC_SW) && bus.mem_ready;
        if (!bus.mem_ready)              state_d = S_MEM;
        else if (bus.opcode == OPC_LW)   state_d = S_WB;
        else                             state_d = S_IF;
      end
      S_WB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        reg_dst    = (bus.opcode == OPC_R);
        mem_to_reg = (bus.opcode == OPC_LW);
      end
      default: ;  // unused encodings fall back to IF with idle outputs
    endcase

    // Outputs must be quiet for the whole reset window, not just after an edge
    if (!rst) begin
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      ir_we      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = ALU_ADD;
      retire     = 1'b0;
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.pc_src     = pc_src;
  assign bus.ir_we      = ir_we;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.iord       = iord;
  assign bus.reg_we     = reg_we;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.retire     = retire;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + 1'b1;
    ret_cnt_d = ret_cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Builds, per instruction, the expected cycle-by-cycle control trace from
//   the instruction-class rules, drives mem_ready/zero from that trace and
//   compares every cycle. Directed cases first, then random instructions,
//   then an asynchronous reset in the middle of a store.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       illegal;
    logic       retire;
  } outv_t;

  typedef struct packed {
    logic  rdy;
    logic  z;
    outv_t o;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if #(.OP_W(6), .ALU_OP_W(4)) bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;
`endif

  multi_cycle_ctrl #(.OP_W(6), .ALU_OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cyc_cnt (cyc_cnt),
    .ret_cnt (ret_cnt)
`endif
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  int    checks   = 0;
  int    failures = 0;
  logic  ill_m;
  int    cyc_m;
  int    ret_m;
  rec_t  trace[$];

  logic [5:0] op_tab [6] = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic outv_t sample();
    outv_t o;
    o.state      = bus.state;
    o.pc_we      = bus.pc_we;
    o.pc_src     = bus.pc_src;
    o.ir_we      = bus.ir_we;
    o.mem_rd     = bus.mem_rd;
    o.mem_wr     = bus.mem_wr;
    o.iord       = bus.iord;
    o.reg_we     = bus.reg_we;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op     = bus.alu_op;
    o.illegal    = bus.illegal;
    o.retire     = bus.retire;
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  // R-type ALU operation from the funct table (unknown funct -> ADD)
  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    for (int k = 0; k < 5; k++)
      if (fn_tab[k] == fn) return 4'(k);
    return 4'd0;
  endfunction

  // Expected trace of one instruction: wif stall cycles in IF, wmem in MEM.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int wif, input int wmem, input int zsel);
    rec_t r;
    trace.delete();
    for (int w = 0; w <= wif; w++) begin
      r = '0; r.o.illegal = ill_m; r.z = 1'($urandom);
      r.o.mem_rd = 1'b1; r.o.alu_src_b = 2'd1;
      r.rdy = (w == wif);
      r.o.ir_we = r.rdy; r.o.pc_we = r.rdy;
      trace.push_back(r);
    end
    r = '0; r.o.illegal = ill_m; r.z = 1'($urandom); r.rdy = 1'($urandom);
    r.o.state = 3'd1; r.o.alu_src_b = 2'd3;
    trace.push_back(r);
    if (!is_legal(op)) begin
      ill_m = 1'b1;
      return;
    end
    r = '0; r.o.illegal = ill_m; r.rdy = 1'($urandom);
    r.z = (zsel == 2) ? 1'($urandom) : 1'(zsel);
    r.o.state = 3'd2;
    if (op == OP_R) begin
      r.o.alu_src_a = 1'b1; r.o.alu_op = alu_of(fn);
    end else if (op == OP_BEQ) begin
      r.o.alu_src_a = 1'b1; r.o.alu_op = 4'd1; r.o.pc_src = 2'd1;
      r.o.pc_we = r.z; r.o.retire = 1'b1;
    end else if (op == OP_J) begin
      r.o.pc_src = 2'd2; r.o.pc_we = 1'b1; r.o.retire = 1'b1;
    end else begin
      r.o.alu_src_a = 1'b1; r.o.alu_src_b = 2'd2;
    end
    trace.push_back(r);
    if (op == OP_LW || op == OP_SW) begin
      for (int w = 0; w <= wmem; w++) begin
        r = '0; r.o.illegal = ill_m; r.z = 1'($urandom);
        r.o.state = 3'd3; r.o.iord = 1'b1;
        r.rdy = (w == wmem);
        r.o.mem_rd = (op == OP_LW);
        r.o.mem_wr = (op == OP_SW);
        r.o.retire = (op == OP_SW) && r.rdy;
        trace.push_back(r);
      end
    end
    if (op == OP_R || op == OP_ADDI || op == OP_LW) begin
      r = '0; r.o.illegal = ill_m; r.z = 1'($urandom); r.rdy = 1'($urandom);
      r.o.state = 3'd4; r.o.reg_we = 1'b1; r.o.retire = 1'b1;
      r.o.reg_dst = (op == OP_R); r.o.mem_to_reg = (op == OP_LW);
      trace.push_back(r);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the last cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int wif, input int wmem, input int zsel,
                           input int abort_at);
    int n;
    build(op, fn, wif, wmem, zsel);
    n = trace.size();
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = trace[i].rdy;
      bus.zero      = trace[i].z;
      #1;
      check_value($sformatf("cycle%0d_op%b", i, op), 32'(sample()), 32'(trace[i].o));
      if (i == abort_at) begin
        #2 rst = 1'b0;
        #1;
        check_value("rst_async_outputs", 32'(sample()), 32'd0);
        @(negedge clk);
        check_value("rst_hold_outputs", 32'(sample()), 32'd0);
        rst   = 1'b1;
        ill_m = 1'b0;
        cyc_m = 0;
        ret_m = 0;
`ifdef CTRL_PERF_CNT_EN
        check_value("cyc_cnt_rst", cyc_cnt, 32'd0);
        check_value("ret_cnt_rst", ret_cnt, 32'd0);
`endif
        $display("instr op=%b fn=%b aborted by reset at cycle %0d", op, fn, i);
        return;
      end
      @(negedge clk);
    end
    cyc_m += n;
    if (is_legal(op)) ret_m++;
`ifdef CTRL_PERF_CNT_EN
    check_value("cyc_cnt", cyc_cnt, 32'(cyc_m));
    check_value("ret_cnt", ret_cnt, 32'(ret_m));
`endif
    $display("instr op=%b fn=%b wif=%0d wmem=%0d cycles=%0d illegal=%0b",
             op, fn, wif, wmem, n, ill_m);
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    ill_m = 1'b0;
    cyc_m = 0;
    ret_m = 0;

    #2 rst = 1'b0;
    @(negedge clk);
    check_value("reset_outputs", 32'(sample()), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check_value("cyc_cnt_init", cyc_cnt, 32'd0);
    check_value("ret_cnt_init", ret_cnt, 32'd0);
`endif
    rst = 1'b1;

    // Directed cases
    run_instr(OP_R,    6'b100000, 0, 0, 2, -1);  // add: 4 cycles
    run_instr(OP_LW,   6'b000000, 0, 0, 2, -1);  // lw: 5 cycles
    run_instr(OP_BEQ,  6'b000000, 0, 0, 1, -1);  // taken
    run_instr(OP_BEQ,  6'b000000, 0, 0, 0, -1);  // not taken
    run_instr(OP_SW,   6'b000000, 3, 2, 2, -1);  // 9 cycles with stalls
    run_instr(OP_R,    6'b101010, 1, 0, 2, -1);  // slt
    run_instr(OP_R,    6'b111111, 0, 0, 2, -1);  // unknown funct -> ADD
    run_instr(OP_J,    6'b000000, 2, 0, 2, -1);
    run_instr(6'b111111, 6'b000000, 0, 0, 2, -1); // undefined opcode
    run_instr(OP_ADDI, 6'b000000, 0, 0, 2, -1);  // flag must persist

    // Random instructions
    repeat (150) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = op_tab[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 1) == 1) fn = fn_tab[$urandom_range(0, 4)];
      else                           fn = 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2, -1);
    end

    // Reset while a store is waiting in MEM (first MEM cycle is index wif+3)
    run_instr(OP_SW, 6'b000000, 0, 3, 2, 3);
    run_instr(OP_R,  6'b100000, 0, 0, 2, -1);
    run_instr(OP_LW, 6'b000000, 1, 1, 2, -1);
    repeat (20) begin
      op = op_tab[$urandom_range(0, 5)];
      fn = fn_tab[$urandom_range(0, 4)];
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
